// File: rtl/writeback_regfile_pkg.sv
// Shared writeback definitions: result-select encodings and datapath/index widths
// used by the writeback stage, the pipeline registers and decode.
package writeback_regfile_pkg;

    localparam int WB_XLEN   = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = $clog2(REG_NUM);

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

endpackage

// File: rtl/wb_result_mux.sv
// Four-way writeback result selector; also instantiated by the forwarding unit.
module wb_result_mux
    import writeback_regfile_pkg::*;
#(
    parameter int W = WB_XLEN
) (
    input  logic [1:0]   ResultSrc,
    input  logic [W-1:0] ALUResult,
    input  logic [W-1:0] ReadData,
    input  logic [W-1:0] PCPlus4,
    input  logic [W-1:0] ExtImm,
    output logic [W-1:0] Result
);

    // Select the writeback source; every encoding is legal
    always_comb begin
        Result = ALUResult;
        case (ResultSrc)
            RES_ALU: Result = ALUResult;
            RES_MEM: Result = ReadData;
            RES_PC4: Result = PCPlus4;
            RES_IMM: Result = ExtImm;
            default: Result = ALUResult;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, integer register file with write-first bypass
// on both read ports, and a counter of committed non-x0 writes.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int NREG  = REG_NUM,
    parameter int CNT_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    RegWrite,
    input  logic [1:0]              ResultSrc,
    input  logic [$clog2(NREG)-1:0] RegAdrWrite,
    input  logic [XLEN-1:0]         ALUResult,
    input  logic [XLEN-1:0]         ReadData,
    input  logic [XLEN-1:0]         PCPlus4,
    input  logic [XLEN-1:0]         ExtImm,
    input  logic [$clog2(NREG)-1:0] Rs1Adr,
    input  logic [$clog2(NREG)-1:0] Rs2Adr,
    output logic [XLEN-1:0]         Rs1Data,
    output logic [XLEN-1:0]         Rs2Data,
    output logic [XLEN-1:0]         Result,
    output logic [CNT_W-1:0]        WbCount
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  regs_r [NREG];
    logic [CNT_W-1:0] wb_count_r;
    logic [XLEN-1:0]  result_s;
    logic             commit_s;
    logic [XLEN-1:0]  rs1_data_s;
    logic [XLEN-1:0]  rs2_data_s;

    wb_result_mux #(.W(XLEN)) u_result_mux (
        .ResultSrc (ResultSrc),
        .ALUResult (ALUResult),
        .ReadData  (ReadData),
        .PCPlus4   (PCPlus4),
        .ExtImm    (ExtImm),
        .Result    (result_s)
    );

    // x0 is never a commit target, so entry 0 stays at its reset value of zero
    assign commit_s = RegWrite && !reset && (RegAdrWrite != {AW{1'b0}});

    // Register array: clear on reset, otherwise commit the selected result
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[RegAdrWrite] <= result_s;
        end
    end

    // Retired-write counter, wraps silently
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_count_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            wb_count_r <= wb_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wb_count_r <= wb_count_r;
        end
    end

    // Read ports with write-first bypass; x0 always reads zero
    always_comb begin
        rs1_data_s = {XLEN{1'b0}};
        rs2_data_s = {XLEN{1'b0}};
        if (Rs1Adr == {AW{1'b0}}) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (commit_s && (Rs1Adr == RegAdrWrite)) begin
            rs1_data_s = result_s;
        end else begin
            rs1_data_s = regs_r[Rs1Adr];
        end
        if (Rs2Adr == {AW{1'b0}}) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (commit_s && (Rs2Adr == RegAdrWrite)) begin
            rs2_data_s = result_s;
        end else begin
            rs2_data_s = regs_r[Rs2Adr];
        end
    end

    assign Rs1Data = rs1_data_s;
    assign Rs2Data = rs2_data_s;
    assign Result  = result_s;
    assign WbCount = wb_count_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: a reference register-file model pushes
// expected outputs per cycle; they are popped and compared before the clock edge.
module tb_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [1:0]  ResultSrc = 2'b00;
    logic [4:0]  RegAdrWrite = 5'd0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] ReadData = 32'h0;
    logic [31:0] PCPlus4 = 32'h0;
    logic [31:0] ExtImm = 32'h0;
    logic [4:0]  Rs1Adr = 5'd0;
    logic [4:0]  Rs2Adr = 5'd0;
    logic [31:0] Rs1Data;
    logic [31:0] Rs2Data;
    logic [31:0] Result;
    logic [3:0]  WbCount;

    writeback_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .RegAdrWrite (RegAdrWrite),
        .ALUResult   (ALUResult),
        .ReadData    (ReadData),
        .PCPlus4     (PCPlus4),
        .ExtImm      (ExtImm),
        .Rs1Adr      (Rs1Adr),
        .Rs2Adr      (Rs2Adr),
        .Rs1Data     (Rs1Data),
        .Rs2Data     (Rs2Data),
        .Result      (Result),
        .WbCount     (WbCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [3:0]  m_cnt = 4'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, push model expectations, compare, clock, update model
    task automatic step(input string tag, input logic rst, input logic rw,
                        input logic [1:0] src, input logic [4:0] wa,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] alu, input logic [31:0] rd = 32'h22,
                        input logic [31:0] pc4 = 32'h33, input logic [31:0] imm = 32'h44);
        logic [31:0] mres;
        logic        commit;
        exp_t        e;
        reset = rst; RegWrite = rw; ResultSrc = src; RegAdrWrite = wa;
        ALUResult = alu; ReadData = rd; PCPlus4 = pc4; ExtImm = imm;
        Rs1Adr = r1; Rs2Adr = r2;
        case (src)
            2'b00:   mres = alu;
            2'b01:   mres = rd;
            2'b10:   mres = pc4;
            default: mres = imm;
        endcase
        commit = rw && !rst && (wa != 5'd0);
        sb_q.push_back('{{tag, ".result"}, 0, mres});
        sb_q.push_back('{{tag, ".rs1"}, 1,
            (r1 == 5'd0) ? 32'h0 : ((commit && r1 == wa) ? mres : m_regs[r1])});
        sb_q.push_back('{{tag, ".rs2"}, 2,
            (r2 == 5'd0) ? 32'h0 : ((commit && r2 == wa) ? mres : m_regs[r2])});
        sb_q.push_back('{{tag, ".cnt"}, 3, {28'h0, m_cnt}});
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       check(e.tag, Result, e.exp);
                1:       check(e.tag, Rs1Data, e.exp);
                2:       check(e.tag, Rs2Data, e.exp);
                default: check(e.tag, {28'h0, WbCount}, e.exp);
            endcase
        end
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 4'd0;
        end else if (commit) begin
            m_regs[wa] = mres;
            m_cnt = m_cnt + 4'd1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        // Reset held two cycles with a pending write to x5
        reset = 1'b1; RegWrite = 1'b1; RegAdrWrite = 5'd5; ALUResult = 32'hDEADBEEF;
        @(posedge clock); #1;
        step("rst_hold", 1'b1, 1'b1, 2'b00, 5'd5, 5'd5, 5'd0, 32'hDEADBEEF);
        step("rst_after", 1'b0, 1'b0, 2'b00, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF);

        // Each result source written to x1..x4, read back through Rs2 bypass
        for (int i = 0; i < 4; i++)
            step("mux_wr", 1'b0, 1'b1, 2'(i), 5'(i + 1), 5'd0, 5'(i + 1), 32'h11);
        step("mux_rd12", 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 5'd2, 32'h0);
        check("x1_const", Rs1Data, 32'h11);
        check("x2_const", Rs2Data, 32'h22);
        step("mux_rd34", 1'b0, 1'b0, 2'b00, 5'd0, 5'd3, 5'd4, 32'h0);
        check("x3_const", Rs1Data, 32'h33);
        check("x4_const", Rs2Data, 32'h44);
        check("cnt_four", {28'h0, WbCount}, 32'd4);

        // x0 writes are discarded and not counted
        step("x0_wr", 1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        step("x0_rd", 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        check("x0_cnt", {28'h0, WbCount}, 32'd4);

        // Bypass on both ports versus no bypass when RegWrite=0
        step("byp_init", 1'b0, 1'b1, 2'b00, 5'd7, 5'd0, 5'd0, 32'h100);
        step("byp_off", 1'b0, 1'b0, 2'b00, 5'd7, 5'd7, 5'd7, 32'h200);
        check("byp_off_c", Rs1Data, 32'h100);
        step("byp_on", 1'b0, 1'b1, 2'b00, 5'd7, 5'd7, 5'd7, 32'h200);
        step("byp_after", 1'b0, 1'b0, 2'b00, 5'd0, 5'd7, 5'd7, 32'h0);
        check("byp_after_c", Rs2Data, 32'h200);

        // Counter wrap: 16 commits from zero with idle cycles in between
        step("wrap_rst", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step("wrap_wr", 1'b0, 1'b1, 2'($urandom_range(3)), 5'(10 + (i % 8)),
                 5'($urandom_range(31)), 5'(10 + (i % 8)), $urandom, $urandom,
                 $urandom, $urandom);
            step("wrap_idle", 1'b0, 1'b0, 2'b00, 5'(10 + (i % 8)),
                 5'($urandom_range(31)), 5'($urandom_range(31)), $urandom);
        end
        check("wrap_zero", {28'h0, WbCount}, 32'd0);

        // Reset mid-stream drops the write; the next write commits
        step("mid_wr_rst", 1'b1, 1'b1, 2'b00, 5'd9, 5'd9, 5'd0, 32'h999);
        step("mid_rd", 1'b0, 1'b0, 2'b00, 5'd0, 5'd9, 5'd9, 32'h0);
        check("mid_x9_zero", Rs1Data, 32'h0);
        step("mid_wr", 1'b0, 1'b1, 2'b00, 5'd9, 5'd0, 5'd0, 32'hABC);
        step("mid_rd2", 1'b0, 1'b0, 2'b00, 5'd0, 5'd9, 5'd0, 32'h0);
        check("mid_x9_abc", Rs1Data, 32'hABC);
        check("mid_cnt", {28'h0, WbCount}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered writeback bundle, selects the result, and commits it to the 32-entry integer register file.
- Provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Exposes the selected result for EX-stage forwarding and keeps a retired-write counter.

Parameters:
- XLEN, 32, data width of registers and result
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5)
- CNT_W, 32, width of the retired-write counter

Ports:
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- RegWrite  input  1  writeback enable from the MEM/WB register
- ResultSrc  input  2  result select: 00 ALUResult, 01 ReadData, 10 PCPlus4, 11 ExtImm
- RegAdrWrite  input  5  destination register index
- ALUResult  input  XLEN  ALU result
- ReadData  input  XLEN  data-memory load data
- PCPlus4  input  XLEN  link value for JAL/JALR
- ExtImm  input  XLEN  extended immediate (LUI)
- Rs1Adr  input  5  read port 1 index
- Rs2Adr  input  5  read port 2 index
- Rs1Data  output  XLEN  read port 1 data
- Rs2Data  output  XLEN  read port 2 data
- Result  output  XLEN  selected writeback value, combinational, for forwarding
- WbCount  output  CNT_W  number of committed non-x0 writes

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is `clock`.
- Reset: on a posedge with reset=1, all NREG entries clear to 0 and WbCount clears to 0. No write is committed in that cycle, even if RegWrite=1.
- Result mux: combinational, purely from ResultSrc and the four data inputs. It has no reset dependence. There is no illegal encoding; all four encodings are used.
- Write commit:
  - On a posedge with reset=0, RegWrite=1 and RegAdrWrite!=0, store Result into entry RegAdrWrite.
  - Latency: visible in the array on the next cycle.
- x0 handling:
  - Writes to index 0 are discarded; entry 0 always holds 0.
  - Reads of index 0 return 0 regardless of the bypass.
- Read ports:
  - Combinational from the array.
  - Bypass: if RegWrite=1, reset=0, RegAdrWrite!=0 and RsNAdr==RegAdrWrite, then RsNData=Result in the same cycle (write-first semantics). This removes the WB->ID hazard.
  - During reset=1 the bypass is disabled and reads return array contents.
- Both read ports may select the same index, including the write index. Both then receive the bypassed value.
- WbCount:
  - Increments by 1 on every committed write (same condition as the write commit).
  - Wraps from 2^CNT_W-1 to 0 without flagging.
  - Does not increment for x0 writes or when RegWrite=0.
- Reset asserted mid-stream: the pending write in that cycle is dropped. The first post-reset cycle behaves normally.
- No stall or flush inputs: bubbles arrive as RegWrite=0 from the upstream register.

Decomposition:
- Shared package holds:
  - ResultSrc encodings as constants: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11.
  - XLEN and register-index width constants, shared with the pipeline registers and decode.
- One sub-module, wb_result_mux: the four-way combinational result selector. It is reused by the forwarding unit.
- Array, bypass and counter stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with RegWrite=1, RegAdrWrite=5, ALUResult=0xDEADBEEF -> Rs1Adr=5 reads 0, WbCount=0, and entry 5 still reads 0 after reset drops with RegWrite=0.
- Mux and write: for each ResultSrc 00/01/10/11 with ALU=0x11, Read=0x22, PC4=0x33, Imm=0x44, write to x1..x4 -> Result matches each source; next cycle Rs1/Rs2 read x1=0x11, x2=0x22, x3=0x33, x4=0x44; WbCount=4.
- x0: RegWrite=1, RegAdrWrite=0, ALU=0xFFFFFFFF, Rs1Adr=0 -> Rs1Data=0 in the same and next cycle; WbCount unchanged.
- Bypass: x7 holds 0x100; write x7 with 0x200 while Rs1Adr=Rs2Adr=7 -> both read 0x200 in the same cycle; with RegWrite=0 the same setup reads 0x100.
- Counter wrap: CNT_W=4, 16 committed writes from 0 -> WbCount returns to 0; interleaved RegWrite=0 cycles do not count.
- Mid-stream reset: a write to x9 in the same cycle as reset -> x9 reads 0 afterwards, and the next write commits normally.
